regfile_multiport: RTL and testbench

//  Parametrised integer register file for the RISC-V core; next generation of the 2R/1W file.

---
 rtl/regfile_multiport_if.sv | 26 ++
 rtl/regfile_multiport.sv | 116 +++++++++++
 tb/tb_regfile_multiport.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: one write port plus NUM_READ flat read ports.
// The decode/writeback side uses the master modport; the register file uses slave.
interface regfile_multiport_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                     ready;
  logic                     writeEn;
  logic [AW-1:0]            writeAddr;
  logic [XLEN-1:0]          writeData;
  logic [NUM_READ*AW-1:0]   readAddr;
  logic [NUM_READ*XLEN-1:0] readData;

  modport master (
    input  ready, readData,
    output writeEn, writeAddr, writeData, readAddr
  );

  modport slave (
    output ready, readData,
    input  writeEn, writeAddr, writeData, readAddr
  );
endinterface

// File: rtl/regfile_multiport.sv
// Integer register file: NUM_READ combinational read ports, one write port,
// optional hardwired-zero register 0. After reset a sequencer zeroes one entry
// per cycle so the storage array carries no reset and can map onto RAM.
// Define REGFILE_BYPASS_EN to forward a committing write to same-cycle reads.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_multiport_if.slave  rf
);
  localparam int              AW         = $clog2(NUM_REGS);
  localparam logic [AW:0]     NUM_REGS_W = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0]   LAST_IDX   = AW'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            ready_q;

  logic [XLEN-1:0] mem_q [NUM_REGS];

  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic [AW-1:0]   rd_addr;
  logic [NUM_READ*XLEN-1:0] rd_flat;

  // Addresses beyond the last implemented register are treated as absent.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write commits only in READY, to an implemented, non-hardwired register.
  assign wr_ok = (state_q == READY) && rf.writeEn &&
                 in_range(rf.writeAddr) && !is_zero_reg(rf.writeAddr);

  // Clear/ready sequencer: walks clr_cnt_q over every entry, then parks in READY.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + AW'(1);
      if (clr_cnt_q == LAST_IDX) begin
        state_q <= READY;
        ready_q <= 1'b1;
      end
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Single storage write port shared by the clear sequencer and the external write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mem_we = 1'b0;
    mem_wa = clr_cnt_q;
    mem_wd = '0;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we = 1'b1;
      end else if (wr_ok) begin
        mem_we = 1'b1;
        mem_wa = rf.writeAddr;
        mem_wd = rf.writeData;
      end
    end
  end

  // Storage array; the reset edge leaves contents untouched.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the clear sequencer zeroes it so it stays RAM-mappable.
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // Per-port combinational read with clear, range, zero-reg and optional bypass rules.
  always_comb begin
    rd_flat = '0;
    rd_addr = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rd_addr = rf.readAddr[p*AW +: AW];
      if ((state_q == READY) && in_range(rd_addr) && !is_zero_reg(rd_addr)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rd_addr == rf.writeAddr)) begin
          rd_flat[p*XLEN +: XLEN] = rf.writeData;
        end else begin
          rd_flat[p*XLEN +: XLEN] = mem_q[rd_addr];
        end
`else
        rd_flat[p*XLEN +: XLEN] = mem_q[rd_addr];
`endif
      end
    end
  end

  assign rf.readData = rd_flat;
  assign rf.ready    = ready_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport. Three instances run in lockstep:
//   d0: 32 regs, 2 read ports, zero reg on
//   d1: 32 regs, 2 read ports, zero reg off
//   d2: 20 regs, 3 read ports, zero reg on
// Stimulus pushes expected values; a negedge monitor pops and compares them.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_multiport_if #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2)) if0 ();
  regfile_multiport_if #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2)) if1 ();
  regfile_multiport_if #(.XLEN(32), .NUM_REGS(20), .NUM_READ(3)) if2 ();

  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG(1)) u_d0 (
    .clk (clk), .rst (rst), .rf (if0)
  );
  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG(0)) u_d1 (
    .clk (clk), .rst (rst), .rf (if1)
  );
  regfile_multiport #(.XLEN(32), .NUM_REGS(20), .NUM_READ(3), .ZERO_REG(1)) u_d2 (
    .clk (clk), .rst (rst), .rf (if2)
  );

  // Per-instance drive and observe views (all instances have 5-bit addresses).
  logic        we [3];
  logic [4:0]  wa [3];
  logic [31:0] wd [3];
  logic [4:0]  ra [3][3];
  logic        rdy [3];
  logic [31:0] rdata [3][3];

  assign if0.writeEn   = we[0];
  assign if0.writeAddr = wa[0];
  assign if0.writeData = wd[0];
  assign if0.readAddr  = {ra[0][1], ra[0][0]};
  assign if1.writeEn   = we[1];
  assign if1.writeAddr = wa[1];
  assign if1.writeData = wd[1];
  assign if1.readAddr  = {ra[1][1], ra[1][0]};
  assign if2.writeEn   = we[2];
  assign if2.writeAddr = wa[2];
  assign if2.writeData = wd[2];
  assign if2.readAddr  = {ra[2][2], ra[2][1], ra[2][0]};

  assign rdy[0]      = if0.ready;
  assign rdy[1]      = if1.ready;
  assign rdy[2]      = if2.ready;
  assign rdata[0][0] = if0.readData[31:0];
  assign rdata[0][1] = if0.readData[63:32];
  assign rdata[0][2] = '0;
  assign rdata[1][0] = if1.readData[31:0];
  assign rdata[1][1] = if1.readData[63:32];
  assign rdata[1][2] = '0;
  assign rdata[2][0] = if2.readData[31:0];
  assign rdata[2][1] = if2.readData[63:32];
  assign rdata[2][2] = if2.readData[95:64];

  typedef struct {
    string       name;
    int          dut;
    int          port;
    bit          is_rdy;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void push_data(input string name, input int d, input int p,
                                    input logic [31:0] v);
    exp_t e;
    e.name = name; e.dut = d; e.port = p; e.is_rdy = 1'b0; e.exp = v;
    sb_q.push_back(e);
  endfunction

  function automatic void push_rdy(input string name, input int d, input logic v);
    exp_t e;
    e.name = name; e.dut = d; e.port = 0; e.is_rdy = 1'b1; e.exp = {31'b0, v};
    sb_q.push_back(e);
  endfunction

  // Monitor: outputs are combinational, so every pending expectation is
  // compared at the negedge following the stimulus that queued it.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_rdy) check(e.name, {31'b0, rdy[e.dut]}, e.exp);
      else          check(e.name, rdata[e.dut][e.port], e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) we[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [4:0] a, input logic [31:0] v);
    we[d] = 1'b1;
    wa[d] = a;
    wd[d] = v;
  endtask

  // Count clear edges after rst release, checking ready on every edge.
  // With hit5, d0 keeps writing reg 5 and reading it during the clear.
  task automatic run_clear(input bit hit5);
    if (hit5) begin
      wr(0, 5'd5, 32'hBAD5_BAD5);
      ra[0][0] = 5'd5;
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 32) idle();
      push_rdy($sformatf("ready_d0_k%0d", k), 0, k >= 32);
      push_rdy($sformatf("ready_d1_k%0d", k), 1, k >= 32);
      push_rdy($sformatf("ready_d2_k%0d", k), 2, k >= 20);
      if (hit5 && k < 32) push_data($sformatf("clr_rd5_k%0d", k), 0, 0, 32'h0);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      for (int d = 0; d < 3; d++) wr(d, 5'(i), 32'h1000 + 32'(i));
      step();
    end
    idle();
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      ra[0][0] = 5'(a);
      ra[0][1] = 5'(31 - a);
      ra[1][0] = 5'(a);
      ra[2][0] = 5'(a);
      push_data($sformatf("%s_d0p0_a%0d", tag, a), 0, 0, 32'h0);
      push_data($sformatf("%s_d0p1_a%0d", tag, a), 0, 1, 32'h0);
      push_data($sformatf("%s_d1_a%0d", tag, a), 1, 0, 32'h0);
      push_data($sformatf("%s_d2_a%0d", tag, a), 2, 0, 32'h0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      we[d] = 1'b0; wa[d] = '0; wd[d] = '0;
      for (int p = 0; p < 3; p++) ra[d][p] = '0;
    end

    // Reset state
    step();
    step();
    for (int d = 0; d < 3; d++) push_rdy($sformatf("rst_ready_d%0d", d), d, 1'b0);
    push_data("rst_rd_d0", 0, 0, 32'h0);
    push_data("rst_rd_d1", 1, 1, 32'h0);
    push_data("rst_rd_d2", 2, 2, 32'h0);
    step();

    // Initial clear, then fill every register
    rst = 1'b0;
    run_clear(1'b0);
    preload();
    ra[0][0] = 5'd31; ra[0][1] = 5'd0;
    ra[1][0] = 5'd0;
    ra[2][0] = 5'd19; ra[2][1] = 5'd25; ra[2][2] = 5'd20;
    push_data("pre_d0_r31", 0, 0, 32'h101F);
    push_data("pre_d0_r0",  0, 1, 32'h0);
    push_data("pre_d1_r0",  1, 0, 32'h1000);
    push_data("pre_d2_r19", 2, 0, 32'h1013);
    push_data("pre_d2_r25", 2, 1, 32'h0);
    push_data("pre_d2_r20", 2, 2, 32'h0);
    step();

    // Test 1: one-edge reset over filled storage, writes to reg 5 during clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_clear(1'b1);
    sweep_zero("clr1");

    // Test 2: basic write then dual-port read
    wr(0, 5'd7, 32'hDEAD_BEEF);
    step();
    idle();
    ra[0][0] = 5'd7; ra[0][1] = 5'd7;
    push_data("rw_p0_r7", 0, 0, 32'hDEAD_BEEF);
    push_data("rw_p1_r7", 0, 1, 32'hDEAD_BEEF);
    step();

    // Test 3: reg 0 hardwired on d0, ordinary on d1 (incl. same-cycle read)
    wr(0, 5'd0, 32'h1234);
    wr(1, 5'd0, 32'h1234);
    ra[0][1] = 5'd0;
    ra[1][0] = 5'd0;
    push_data("zr_same_d0", 0, 1, 32'h0);
    push_data("zr_same_d1", 1, 0, BYPASS ? 32'h1234 : 32'h0);
    step();
    idle();
    push_data("zr_next_d0", 0, 1, 32'h0);
    push_data("zr_next_d1", 1, 0, 32'h1234);
    step();

    // Test 4: same-cycle write/read hazard on reg 3, port 1 reads reg 7
    wr(0, 5'd3, 32'h11);
    step();
    wr(0, 5'd3, 32'h22);
    ra[0][0] = 5'd3; ra[0][1] = 5'd7;
    push_data("haz_same_r3", 0, 0, BYPASS ? 32'h22 : 32'h11);
    push_data("haz_same_r7", 0, 1, 32'hDEAD_BEEF);
    step();
    idle();
    push_data("haz_next_r3", 0, 0, 32'h22);
    step();

    // Test 6: 20-entry, 3-port instance
    wr(2, 5'd25, 32'h5555);
    ra[2][0] = 5'd25; ra[2][1] = 5'd0; ra[2][2] = 5'd19;
    push_data("np2_oor_same", 2, 0, 32'h0);
    push_data("np2_r0_same",  2, 1, 32'h0);
    push_data("np2_r19_clr",  2, 2, 32'h0);
    step();
    idle();
    push_data("np2_oor_next", 2, 0, 32'h0);
    step();
    wr(2, 5'd1, 32'hA1);
    step();
    wr(2, 5'd2, 32'hB2);
    step();
    wr(2, 5'd19, 32'hC3);
    step();
    idle();
    ra[2][0] = 5'd1; ra[2][1] = 5'd2; ra[2][2] = 5'd19;
    push_data("np2_p0_r1",  2, 0, 32'hA1);
    push_data("np2_p1_r2",  2, 1, 32'hB2);
    push_data("np2_p2_r19", 2, 2, 32'hC3);
    step();
    ra[2][0] = 5'd19; ra[2][1] = 5'd19; ra[2][2] = 5'd19;
    for (int p = 0; p < 3; p++) push_data($sformatf("np2_same_p%0d", p), 2, p, 32'hC3);
    step();

    // Test 5: reset restarted at clear step 10 over refilled storage
    preload();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    push_rdy("mid_ready_d0", 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_clear(1'b0);
    sweep_zero("clr2");

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
